// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited imem requests, in-order response buffer, redirect flush.
// Optional misaligned-redirect pulse on o_misalign when FETCH_MISALIGN_CHK_EN is defined.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req_vld,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_req_rdy,
    input  logic        i_imem_rsp_vld,
    input  logic [31:0] i_imem_rsp_data,
    output logic        o_inst_vld,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    input  logic        i_inst_rdy,
    output logic        o_misalign,
    output logic [1:0]  o_dbg_state
);

    localparam int CW    = $clog2(BUF_DEPTH + 1);
    localparam int PW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int NSLOT = 1 << PW;
    localparam logic [PW-1:0] PTR_LAST = PW'(BUF_DEPTH - 1);
    localparam logic [CW:0]   CREDITS  = (CW + 1)'(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] buf_cnt;
    logic [CW-1:0] drop_cnt;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   buf_inst [NSLOT];
    logic [31:0]   buf_pc   [NSLOT];

    logic [CW:0]   inflight;
    logic          req_xfer;
    logic          discard;
    logic          push;
    logic          pop;
    logic [31:0]   target;
    logic [CW-1:0] drop_next;

    // Valid/ready: a beat moves when valid and ready are both high on a rising edge; a raised
    // request holds address until accepted, and only a same-cycle redirect may withdraw it.
    assign inflight       = {1'b0, out_cnt} + {1'b0, buf_cnt};
    assign o_imem_req_vld = (state == ST_FETCH) && (inflight < CREDITS) && !i_redirect;
    assign o_imem_addr    = o_imem_req_vld ? fetch_pc : 32'h0;
    assign req_xfer       = o_imem_req_vld && i_imem_req_rdy;

    // Responses still owed to a redirected stream are dropped, including one landing with the redirect.
    assign discard   = i_redirect || (drop_cnt != '0);
    assign push      = i_imem_rsp_vld && !discard;
    assign pop       = o_inst_vld && i_inst_rdy;
    assign target    = {i_redirect_pc[31:2], 2'b00};
    assign drop_next = out_cnt - CW'(i_imem_rsp_vld);

    assign o_inst_vld  = (buf_cnt != '0);
    assign o_inst      = o_inst_vld ? buf_inst[head] : 32'h0;
    assign o_pc        = o_inst_vld ? buf_pc[head] : 32'h0;
    assign o_dbg_state = state;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state    <= ST_BOOT;
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            out_cnt  <= '0;
            buf_cnt  <= '0;
            drop_cnt <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            out_cnt <= out_cnt + CW'(req_xfer) - CW'(i_imem_rsp_vld);
            if (i_redirect) begin
                // A decode pop this cycle still completes; whatever remains is flushed.
                fetch_pc <= target;
                rsp_pc   <= target;
                drop_cnt <= drop_next;
                buf_cnt  <= '0;
                head     <= '0;
                tail     <= '0;
                state    <= (drop_next != '0) ? ST_FLUSH : ST_FETCH;
            end else begin
                if (req_xfer) fetch_pc <= fetch_pc + 32'd4;
                if (push) begin
                    rsp_pc <= rsp_pc + 32'd4;
                    tail   <= next_ptr(tail);
                end
                if (pop) head <= next_ptr(head);
                buf_cnt <= buf_cnt + CW'(push) - CW'(pop);
                if ((drop_cnt != '0) && i_imem_rsp_vld) drop_cnt <= drop_cnt - CW'(1);
                case (state)
                    ST_BOOT:  state <= ST_FETCH;
                    ST_FLUSH: begin
                        if ((drop_cnt == '0) || ((drop_cnt == CW'(1)) && i_imem_rsp_vld))
                            state <= ST_FETCH;
                    end
                    default:  state <= state;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            buf_inst[tail] <= i_imem_rsp_data;
            buf_pc[tail]   <= rsp_pc;
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) misalign_q <= 1'b0;
        else          misalign_q <= i_redirect && (i_redirect_pc[1:0] != 2'b00);
    end

    assign o_misalign = misalign_q;
`else
    logic unused_lsb;

    assign unused_lsb = ^i_redirect_pc[1:0];
    assign o_misalign = 1'b0;
`endif

`ifndef SYNTHESIS
    // Credits cover buffered plus outstanding fetches, so a response can never find the buffer full.
    a_no_push_full : assert property (@(posedge i_clk) disable iff (!i_reset)
        !(push && (buf_cnt == CW'(BUF_DEPTH))));
`endif

endmodule
